alu4_seq: RTL

Nibble-serial sequencer that drives the 4-bit ALU datapath as its initiator. It accepts one NIB×4-bit operation through a valid/ready request, and issues it to the ALU one nibble per cycle. Math and rotate carries are chained between nibbles, and the ALU results are collected into a full-width response with aggregate flags. It sits between the instruction front end and the combinational ALU4 core, which widens the core to 16-bit operations by default.

---
 rtl/alu4_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu4_seq.sv
// alu4_seq: nibble-serial sequencer driving a combinational 4-bit ALU core.
// Accepts one NIB x 4-bit operation, issues it one nibble per cycle with carries
// chained between nibbles, and returns the assembled result with flags.
module alu4_seq #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [4*NIB-1:0] req_a,
  input  logic [4*NIB-1:0] req_b,
  input  logic             req_ci,
  input  logic             req_rci,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4*NIB-1:0] rsp_data,
  output logic             rsp_co,
  output logic             rsp_rco,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  // ALU drive
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_ci,
  output logic             alu_rci,
  input  logic [3:0]       alu_out,
  input  logic             alu_co,
  input  logic             alu_rco,
  input  logic             alu_ovf
);

  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  // co_q/rco_q double as the carry chain: loaded with the request carries on
  // accept, then updated with the ALU carries after every nibble step.
  logic          co_q, co_d;
  logic          rco_q, rco_d;
  logic          ovf_q, ovf_d;

  logic          in_run;
  logic          msb_first;
  logic [KW-1:0] nib_idx;
  logic [3:0]    a_nibs [NIB];
  logic [3:0]    b_nibs [NIB];

  assign in_run = (state_q == S_RUN);

  // Right-shift / rotate-right class ops walk from the top nibble down so the
  // rotate carry flows toward the LSB.
  assign msb_first = (op_q == 4'b0111) || (op_q == 4'b1101) || (op_q == 4'b1111);
  assign nib_idx   = msb_first ? (K_LAST - k_q) : k_q;

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[4*gi +: 4];
      assign b_nibs[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  // ALU drive is decoded from registered state only, never from ALU outputs.
  assign alu_op  = in_run ? op_q : 4'd0;
  assign alu_a   = in_run ? a_nibs[nib_idx] : 4'd0;
  assign alu_b   = in_run ? b_nibs[nib_idx] : 4'd0;
  assign alu_ci  = in_run & co_q;
  assign alu_rci = in_run & rco_q;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = res_q;
  assign rsp_co    = co_q;
  assign rsp_rco   = rco_q;
  assign rsp_zero  = (res_q == '0);
  assign rsp_ovf   = ovf_q;

  // Next-state logic: capture on accept, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    co_d    = co_q;
    rco_d   = rco_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_RUN;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          co_d    = req_ci;
          rco_d   = req_rci;
          res_d   = '0;
          ovf_d   = 1'b0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (nib_idx == KW'(i)) begin
            res_d[4*i +: 4] = alu_out;
          end
        end
        co_d  = alu_co;
        rco_d = alu_rco;
        // Overflow only has meaning for the top nibble of an LSB-first op.
        if (!msb_first && (nib_idx == K_LAST)) begin
          ovf_d = alu_ovf;
        end
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      co_q    <= 1'b0;
      rco_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      co_q    <= co_d;
      rco_q   <= rco_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
